router_output_arbiter: RTL

//  Per-output-port wormhole arbiter and credit tracker for one output of the 5-port NoC router.

---
 rtl/router_pkg.sv | 35 +++
 rtl/rr_priority_picker.sv | 37 +++
 rtl/router_output_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and helpers for the NoC router: arbiter FSM states, port
// index names and a reference round-robin winner function.
package router_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  // Router port indices; LOCAL is the injection/ejection port.
  localparam int LOCAL = 0;
  localparam int NORTH = 1;
  localparam int SOUTH = 2;
  localparam int EAST  = 3;
  localparam int WEST  = 4;

  // Widest request vector rr_next accepts.
  localparam int RR_MAX_INPUTS = 16;

  // Index of the first set bit of mask searching upward from ptr+1,
  // wrapping modulo n. Returns ptr when mask is empty.
  function automatic int unsigned rr_next(input logic [RR_MAX_INPUTS-1:0] mask,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned idx;
    logic        found;
    rr_next = ptr;
    found   = 1'b0;
    for (int unsigned i = 1; i <= n; i++) begin
      idx = (ptr + i) % n;
      if (!found && mask[idx]) begin
        found   = 1'b1;
        rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: rotate the request mask so the slot after
// ptr is at bit 0, find the first set bit, then rotate the index back.
module rr_priority_picker #(
  parameter int N = 5,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] winner
);

  logic [N-1:0] rotated;
  int           start;
  int           offset;

  // Rotate, find-first, unrotate.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rotated = '0;
    valid   = 1'b0;
    offset  = 0;
    start   = (int'(ptr) + 1) % N;
    for (int i = 0; i < N; i++) begin
      rotated[i] = mask[(start + i) % N];
    end
    // Descending scan so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        valid  = 1'b1;
        offset = i;
      end
    end
    winner = W'((start + offset) % N);
  end

endmodule

// File: rtl/router_output_arbiter.sv
// Per-output wormhole arbiter and credit tracker for one router output.
// Grants one input per packet (round-robin), holds it until the tail flit,
// gates every flit on downstream credits and drives the crossbar select.
// Optional feature: define ROUTER_ARB_STATS_EN to add pkt_count/stall_count.
module router_output_arbiter
  import router_pkg::*;
#(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 256,
  parameter int SEL_WIDTH         = $clog2(NUM_INPUTS),
  parameter int CRED_WIDTH        = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [NUM_INPUTS-1:0] req_is_tail,
  input  logic [NUM_INPUTS-1:0] turn_mask,
  output logic [NUM_INPUTS-1:0] pop,
  output logic [SEL_WIDTH-1:0]  sel,
  output logic                  send_out,
  output logic                  is_tail_out,
  input  logic                  credit_in,
  output logic [CRED_WIDTH-1:0] credit_cnt,
`ifdef ROUTER_ARB_STATS_EN
  output logic [31:0]           pkt_count,
  output logic [31:0]           stall_count,
`endif
  output logic                  busy
);

  localparam logic [CRED_WIDTH-1:0] CRED_MAX = CRED_WIDTH'(FLIT_BUFFER_DEPTH);

  arb_state_e                state;
  logic [SEL_WIDTH-1:0]      rr_ptr;
  logic [NUM_INPUTS-1:0]     elig;
  logic                      pick_valid;
  logic [SEL_WIDTH-1:0]      pick_winner;
  logic [CRED_WIDTH-1:0]     cnt_next;
  logic                      stalled;

  assign elig = req & ~turn_mask;

  rr_priority_picker #(
    .N (NUM_INPUTS),
    .W (SEL_WIDTH)
  ) u_picker (
    .mask   (elig),
    .ptr    (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Flit transfer: the owner's head flit moves when it is present and a credit is held.
  always_comb begin
    pop = '0;
    if (state == ARB_LOCKED && req[sel] && credit_cnt != '0) begin
      pop[sel] = 1'b1;
    end
  end

  assign send_out    = |pop;
  assign is_tail_out = send_out & req_is_tail[sel];
  assign busy        = (state == ARB_LOCKED);
  assign stalled     = (state == ARB_LOCKED) && req[sel] && (credit_cnt == '0);

  // Credit update: +1 per returned credit, -1 per flit sent, saturating at the buffer depth.
  always_comb begin
    cnt_next = credit_cnt;
    unique case ({credit_in, send_out})
      2'b10:   if (credit_cnt != CRED_MAX) cnt_next = credit_cnt + CRED_WIDTH'(1);
      2'b01:   cnt_next = credit_cnt - CRED_WIDTH'(1);
      default: cnt_next = credit_cnt;
    endcase
  end

  // Arbitration FSM: pick in IDLE, hold the owner in LOCKED until its tail leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
    if (!rst_n) begin
      state  <= ARB_IDLE;
      sel    <= '0;
      rr_ptr <= SEL_WIDTH'(NUM_INPUTS - 1);
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state <= ARB_LOCKED;
            sel   <= pick_winner;
          end
        end
        ARB_LOCKED: begin
          if (is_tail_out) begin
            state  <= ARB_IDLE;
            rr_ptr <= sel;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Credit counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_cnt <= CRED_MAX;
    end else begin
      credit_cnt <= cnt_next;
    end
  end

`ifdef ROUTER_ARB_STATS_EN
  // Statistics: packets completed (wrapping) and credit-starved cycles (saturating).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count   <= '0;
      stall_count <= '0;
    end else begin
      if (is_tail_out) pkt_count <= pkt_count + 32'd1;
      if (stalled && stall_count != '1) stall_count <= stall_count + 32'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = stalled;
`endif

  // A credit returned while the counter is already full means the downstream
  // returned more credits than it was given.
  credit_overflow_a: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(credit_in && !send_out && credit_cnt == CRED_MAX)
  );

endmodule
